// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: multiply FSM states and the
// bundle of pipe-register stall/flush controls.
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic if_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_vec_t;

    function automatic ctrl_vec_t ctrl_idle();
        return '0;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mul_seq.sv
// Multi-cycle multiply sequencer: stalls the front of the pipe for MUL_CYCLES-1
// cycles and flags the result in the final EX cycle.
module mul_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic stall,
    output logic done
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Counter holds the number of stall cycles still owed after the current one.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    stall = start;
                BUSY: begin
                    stall = (cnt != '0);
                    done  = (cnt == '0);
                end
                default: begin
                    stall = 1'b0;
                    done  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: load-use detection, multiply sequencing and
// wrong-path squash, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PERF_W     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_mul_start,
    input  logic                  ex_redirect,
    output logic                  if_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  mul_done,
    output logic [PERF_W-1:0]     stall_count
);

    logic      mul_stall;
    logic      load_use;
    ctrl_vec_t ctrl;

    mul_seq #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul_seq (
        .clock(clock),
        .reset(reset),
        .start(ex_mul_start),
        .stall(mul_stall),
        .done (mul_done)
    );

    always_comb begin
        load_use = ex_mem_to_reg && (ex_rd != REG_ADDR_W'(REG_ZERO)) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
    end

    // Multiply stall outranks redirect; a redirect makes the ID instruction
    // wrong-path, so it also outranks the load-use stall.
    always_comb begin
        ctrl = ctrl_idle();
        if (!reset) begin
            if (mul_stall) begin
                ctrl.if_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_stall  = 1'b1;
                ctrl.ex_mem_flush = 1'b1;
            end else if (ex_redirect) begin
                ctrl.if_id_flush  = 1'b1;
                ctrl.id_ex_flush  = 1'b1;
            end else if (load_use) begin
                ctrl.if_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_flush  = 1'b1;
            end
        end
    end

    assign if_stall     = ctrl.if_stall;
    assign if_id_stall  = ctrl.if_id_stall;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_stall  = ctrl.id_ex_stall;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_flush = ctrl.ex_mem_flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (ctrl.if_stall && (stall_count != {PERF_W{1'b1}})) begin
            stall_count <= stall_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MULC = 4;
    localparam int B_IFS = 6, B_IFIDS = 5, B_IFIDF = 4, B_IDEXS = 3,
                   B_IDEXF = 2, B_EXMF = 1, B_DONE = 0;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_to_reg, ex_mul_start, ex_redirect;

    logic        a_ifs, a_ifids, a_ifidf, a_idexs, a_idexf, a_exmf, a_done;
    logic [31:0] a_cnt;
    logic        b_ifs, b_ifids, b_ifidf, b_idexs, b_idexf, b_exmf, b_done;
    logic [3:0]  b_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: position inside the current multiply (0 = none).
    int     pos = 0;
    longint c32 = 0;
    int     c4  = 0;

    logic [6:0]  exp_vec, act_vec, act_vec4;
    logic [31:0] act_c32;
    logic [3:0]  act_c4;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.MUL_CYCLES(MULC), .REG_ADDR_W(5), .PERF_W(32)) u_dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mul_start(ex_mul_start), .ex_redirect(ex_redirect),
        .if_stall(a_ifs), .if_id_stall(a_ifids), .if_id_flush(a_ifidf),
        .id_ex_stall(a_idexs), .id_ex_flush(a_idexf), .ex_mem_flush(a_exmf),
        .mul_done(a_done), .stall_count(a_cnt)
    );

    pipe_hazard_ctrl #(.MUL_CYCLES(MULC), .REG_ADDR_W(5), .PERF_W(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_mul_start(ex_mul_start), .ex_redirect(ex_redirect),
        .if_stall(b_ifs), .if_id_stall(b_ifids), .if_id_flush(b_ifidf),
        .id_ex_stall(b_idexs), .id_ex_flush(b_idexf), .ex_mem_flush(b_exmf),
        .mul_done(b_done), .stall_count(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, advance the model.
    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic uu1, input logic uu2,
                        input logic lm, input logic mm, input logic rr);
        int  cur;
        bit  lu;
        @(negedge clock);
        reset = r; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        id_uses_rs1 = uu1; id_uses_rs2 = uu2; ex_mem_to_reg = lm;
        ex_mul_start = mm; ex_redirect = rr;
        #1;
        lu  = lm && (rd != 5'd0) && ((uu1 && rs1 == rd) || (uu2 && rs2 == rd));
        cur = r ? 0 : ((pos == 0 && mm) ? 1 : pos);
        exp_vec = '0;
        if (!r) begin
            if (cur >= 1 && cur < MULC) begin
                exp_vec[B_IFS] = 1; exp_vec[B_IFIDS] = 1;
                exp_vec[B_IDEXS] = 1; exp_vec[B_EXMF] = 1;
            end else if (rr) begin
                exp_vec[B_IFIDF] = 1; exp_vec[B_IDEXF] = 1;
            end else if (lu) begin
                exp_vec[B_IFS] = 1; exp_vec[B_IFIDS] = 1; exp_vec[B_IDEXF] = 1;
            end
            if (cur == MULC) exp_vec[B_DONE] = 1;
        end
        act_vec  = {a_ifs, a_ifids, a_ifidf, a_idexs, a_idexf, a_exmf, a_done};
        act_vec4 = {b_ifs, b_ifids, b_ifidf, b_idexs, b_idexf, b_exmf, b_done};
        act_c32  = a_cnt;
        act_c4   = b_cnt;
        chk("ctrl_vec", 32'(act_vec), 32'(exp_vec));
        chk("ctrl_vec_p4", 32'(act_vec4), 32'(exp_vec));
        chk("stall_count", act_c32, 32'(c32));
        chk("stall_count_p4", 32'(act_c4), 32'(c4));
        @(posedge clock);
        if (r) begin
            pos = 0; c32 = 0; c4 = 0;
        end else begin
            if (exp_vec[B_IFS]) begin
                if (c32 < 64'hFFFF_FFFF) c32++;
                if (c4 < 15) c4++;
            end
            pos = (cur == 0 || cur == MULC) ? 0 : cur + 1;
        end
    endtask

    task automatic idle(input logic r);
        step(r, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mul(input logic rr);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, rr);
    endtask

    initial begin
        // Reset state
        idle(1'b1);
        idle(1'b1);
        chk("reset_outputs", 32'(act_vec), 32'd0);
        idle(1'b0);
        chk("reset_count", act_c32, 32'd0);

        // Load-use on rs1, then the bubble in EX clears it; ex_rd=0 never hazards
        step(1'b0, 5'd3, 5'd7, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lu_if_stall", 32'(act_vec[B_IFS]), 32'd1);
        chk("lu_id_ex_flush", 32'(act_vec[B_IDEXF]), 32'd1);
        step(1'b0, 5'd3, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_one_cycle", 32'(act_vec[B_IFS]), 32'd0);
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lu_rd_zero", 32'(act_vec), 32'd0);

        // Two back-to-back multiplies with start held throughout
        for (int k = 0; k < 2; k++) begin
            for (int c = 1; c <= MULC; c++) begin
                mul(1'b0);
                chk("mul_ex_mem_flush", 32'(act_vec[B_EXMF]), (c < MULC) ? 32'd1 : 32'd0);
                chk("mul_done", 32'(act_vec[B_DONE]), (c == MULC) ? 32'd1 : 32'd0);
            end
        end
        idle(1'b0);
        chk("mul_idle_after", 32'(act_vec), 32'd0);

        // Redirect with rs2 load-use: flush wins, no stall
        step(1'b0, 5'd1, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("redir_lu_vec", 32'(act_vec), 32'b0010100);

        // Redirect masked while multiply busy with cnt=1 (third cycle)
        mul(1'b0);
        mul(1'b0);
        mul(1'b1);
        chk("redir_busy_vec", 32'(act_vec), 32'b1101010);
        mul(1'b0);
        idle(1'b0);

        // Reset during BUSY aborts, next multiply takes full length
        mul(1'b0);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_busy_vec", 32'(act_vec), 32'd0);
        mul(1'b0);
        chk("rst_count_zero", act_c32, 32'd0);
        chk("rst_new_mul_stall", 32'(act_vec[B_EXMF]), 32'd1);
        mul(1'b0);
        mul(1'b0);
        chk("rst_new_mul_no_early_done", 32'(act_vec[B_DONE]), 32'd0);
        mul(1'b0);
        chk("rst_new_mul_done", 32'(act_vec[B_DONE]), 32'd1);

        // 20 load-use stalls: 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++)
            step(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("sat_count_p4", 32'(act_c4), 32'd15);
        chk("count_32", act_c32, 32'd23);
        idle(1'b0);
        chk("sat_hold_p4", 32'(act_c4), 32'd15);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
